// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the chain-code byte transmitter.
// Holds the frame constants, the data width and the receiver state type.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  // Index of the final data bit within a frame.
  localparam logic [2:0]  LAST_BIT_IDX = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for an asynchronous single-bit input.
// All flops reset to 1 so an idle UART line reads as idle straight out of reset.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high
//   d     - asynchronous input
//   q     - synchronised output (N clocks of latency)
module uart_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[N-2:0], d};
    end
  end

  assign q = r_sync[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Recovers LSB-first frames from the asynchronous line rx_in, reports each good
// byte with a one-cycle strobe, flags frames whose stop bit is low, and rejects
// start-bit glitches shorter than half a bit period.
// Ports:
//   clk       - system clock, all logic on posedge
//   reset     - asynchronous, active-high
//   rx_in     - serial line, idle high, asynchronous to clk
//   rx_data   - last good byte, held until the next good frame
//   rx_valid  - one-cycle pulse, rx_data updated in the same cycle
//   frame_err - one-cycle pulse when the stop bit samples low
//   rx_busy   - high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic                 w_rx_s;
  uart_rx_state_e       r_state;
  uart_rx_state_e       w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_err;
  logic                 w_valid_nxt;
  logic                 w_err_nxt;
  logic                 w_sample;
  logic                 w_cnt_half;
  logic                 w_cnt_last;

  uart_sync #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (w_rx_s)
  );

  assign w_cnt_half = (r_bit_cnt == CNT_HALF);
  assign w_cnt_last = (r_bit_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_s == START_BIT) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        // Half a period in: still low means a real start bit, otherwise a glitch.
        if (w_cnt_half) begin
          w_state_nxt = (w_rx_s == START_BIT) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        // START consumed half a period, so full-period counts land mid-bit.
        if (w_cnt_last) begin
          w_sample = 1'b1;
          if (r_bit_idx == LAST_BIT_IDX) begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_cnt_last) begin
          if (w_rx_s == STOP_BIT) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Line held low after a bad stop bit: wait for idle before rearming.
        if (w_rx_s == STOP_BIT) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // Cleared on every state change; also wraps explicitly between data bits
      // so non-power-of-two periods work.
      if ((w_state_nxt != r_state) || w_cnt_last) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (r_state != ST_DATA) begin
        r_bit_idx <= '0;
      end else if (w_sample) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (w_sample) begin
        r_shreg[r_bit_idx] <= w_rx_s;
      end

      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      if (w_valid_nxt) begin
        r_data <= r_shreg;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_err;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomised bench for uart_rx. Two instances: one at 4 clocks
// per bit for the functional cases, one at 16 clocks per bit for the
// baud-tolerance case. Expected events come from a frame-level model: a frame
// with a high stop bit yields its byte, one with a low stop bit yields an
// error while rx_data keeps the last good byte.
module tb_uart_rx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned CPB16 = 16;
  localparam int unsigned SYNC  = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx4   = 1'b1;
  logic       rx16  = 1'b1;
  logic [7:0] d4;
  logic       v4;
  logic       e4;
  logic       b4;
  logic [7:0] d16;
  logic       v16;
  logic       e16;
  logic       b16;

  int errors = 0;
  int checks = 0;
  int both_high = 0;
  int unsigned cyc = 0;
  int unsigned t_start = 0;

  // Event encoding: {is_error, rx_data at the pulse}
  logic [8:0]  exp_q[$];
  logic [8:0]  obs_q[$];
  int unsigned obs_cyc[$];
  logic [8:0]  exp16_q[$];
  logic [8:0]  obs16_q[$];
  logic [7:0]  last4 = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx4),
    .rx_data   (d4),
    .rx_valid  (v4),
    .frame_err (e4),
    .rx_busy   (b4)
  );

  uart_rx #(
    .CLKS_PER_BIT (CPB16),
    .SYNC_STAGES  (SYNC)
  ) u_dut16 (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx16),
    .rx_data   (d16),
    .rx_valid  (v16),
    .frame_err (e16),
    .rx_busy   (b16)
  );

  always @(negedge clk) begin
    if (v4) begin
      obs_q.push_back({1'b0, d4});
      obs_cyc.push_back(cyc);
    end
    if (e4) begin
      obs_q.push_back({1'b1, d4});
      obs_cyc.push_back(cyc);
    end
    if (v4 && e4) both_high++;
    if (v16) obs16_q.push_back({1'b0, d16});
    if (e16) obs16_q.push_back({1'b1, d16});
    if (v16 && e16) both_high++;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+2; holds the line level for ncyc clocks.
  task automatic drive4(input logic b, input int unsigned ncyc);
    rx4 = b;
    if (ncyc > 0) begin
      repeat (ncyc) @(posedge clk);
      #2;
    end
  endtask

  task automatic send4(input logic [7:0] d, input logic stop_ok);
    t_start = cyc;
    drive4(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive4(d[i], CPB);
    drive4(stop_ok, CPB);
    if (stop_ok) begin
      exp_q.push_back({1'b0, d});
      last4 = d;
    end else begin
      exp_q.push_back({1'b1, last4});
    end
  endtask

  task automatic send16(input logic [7:0] d, input int unsigned bit_t);
    rx16 = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx16 = d[i];
      #(bit_t);
    end
    rx16 = 1'b1;
    #(bit_t);
    exp16_q.push_back({1'b0, d});
  endtask

  task automatic check_events(input string tag, input bit use16);
    logic [8:0] o[$];
    logic [8:0] e[$];
    logic [8:0] ov;
    logic [8:0] ev;
    if (use16) begin
      o = obs16_q; e = exp16_q;
      obs16_q.delete(); exp16_q.delete();
    end else begin
      o = obs_q; e = exp_q;
      obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    end
    chk({tag, "_count"}, o.size(), e.size());
    while (e.size() > 0) begin
      ev = e.pop_front();
      ov = (o.size() > 0) ? o.pop_front() : 9'bx;
      chk({tag, "_event"}, {23'd0, ov}, {23'd0, ev});
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic        ok;
    int unsigned lat;

    @(posedge clk); #2;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_data", d4, 8'h00);
    chk("reset_valid", v4, 1'b0);
    chk("reset_ferr", e4, 1'b0);
    chk("reset_busy", b4, 1'b0);
    reset = 1'b0;
    drive4(1'b1, 3 * CPB);

    // 1: single clean frame, with latency from the start edge
    send4(8'hA5, 1'b1);
    drive4(1'b1, 3 * CPB);
    lat = (obs_cyc.size() > 0) ? obs_cyc[0] - t_start : 0;
    checks++;
    assert (lat >= 40 && lat <= 42) else begin
      errors++;
      $error("FAIL t1_latency: observed %0d expected 40..42", lat);
    end
    check_events("t1", 1'b0);

    // 2: back-to-back frames with no idle gap
    send4(8'h00, 1'b1);
    send4(8'hFF, 1'b1);
    send4(8'h3C, 1'b1);
    drive4(1'b1, 3 * CPB);
    check_events("t2", 1'b0);

    // 3: one-clock start glitch
    drive4(1'b0, 1);
    drive4(1'b1, 3 * CPB);
    check_events("t3", 1'b0);
    chk("t3_busy", b4, 1'b0);
    chk("t3_data_held", d4, last4);

    // 4: low stop bit, line held low, then a good frame
    send4(8'h5A, 1'b0);
    drive4(1'b0, 3 * CPB);
    drive4(1'b1, CPB);
    chk("t4_data_held", d4, last4);
    send4(8'h81, 1'b1);
    drive4(1'b1, 3 * CPB);
    check_events("t4", 1'b0);

    // 5: reset in the middle of data bit 4
    b = 8'hC3;
    drive4(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive4(b[i], CPB);
    drive4(b[4], 2);
    chk("t5_busy_mid", b4, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_rst_data", d4, 8'h00);
    chk("t5_rst_valid", v4, 1'b0);
    chk("t5_rst_ferr", e4, 1'b0);
    chk("t5_rst_busy", b4, 1'b0);
    rx4 = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    last4 = 8'h00;
    drive4(1'b1, 3 * CPB);
    send4(8'h12, 1'b1);
    drive4(1'b1, 3 * CPB);
    check_events("t5", 1'b0);

    // Random frames: random data, occasional bad stop bit, random gaps
    for (int n = 0; n < 20; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send4(b, ok);
      if (!ok) begin
        drive4(1'b0, CPB * $urandom_range(0, 3));
        drive4(1'b1, CPB);
      end
      drive4(1'b1, CPB * $urandom_range(0, 2));
    end
    drive4(1'b1, 3 * CPB);
    check_events("rand", 1'b0);

    // 6: 16 clocks per bit, line bit period at -3% and +3% of 160
    send16(8'h96, 155);
    send16(8'h96, 165);
    for (int n = 0; n < 4; n++) begin
      send16(8'($urandom), ($urandom_range(0, 1) != 0) ? 165 : 155);
    end
    repeat (3 * CPB16) @(posedge clk);
    #2;
    check_events("t6", 1'b1);

    chk("never_both_high", both_high, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
